retire_rat: RTL

//  Retirement RAT: architectural map of committed state, directly downstream of the ROB commit port.

---
 rtl/retire_rat.sv | 103 ++++++++++
 1 files changed

// File: rtl/retire_rat.sv
// retire_rat: retirement register alias table.
// Holds the architectural (committed) arch->phys map. It sits directly
// downstream of the ROB commit port.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   commit_cnt        number of valid commit slots this cycle (slots 0..cnt-1)
//   rrf_arch_reg[SS]  committed destination arch register per slot
//   rrf_phys_reg[SS]  committed destination phys register per slot
//   mispredict        ROB flush; this cycle's commits still retire
//   freed_valid[SS]   displaced phys register valid (registered)
//   freed_phys[SS]    displaced phys register returned to the free list (registered)
//   restore_valid     mirrors mispredict (combinational)
//   restore_map       committed map including this cycle's commits (combinational)
module retire_rat #(
    parameter int SS        = 2,
    parameter int SS_BITS   = 1,
    parameter int NUM_ARCH  = 32,
    parameter int ARCH_BITS = 5,
    parameter int PHYS_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SS_BITS:0]     commit_cnt,
    input  logic [ARCH_BITS-1:0] rrf_arch_reg [SS],
    input  logic [PHYS_BITS-1:0] rrf_phys_reg [SS],
    input  logic                 mispredict,
    output logic [SS-1:0]        freed_valid,
    output logic [PHYS_BITS-1:0] freed_phys [SS],
    output logic                 restore_valid,
    output logic [PHYS_BITS-1:0] restore_map [NUM_ARCH]
);

    localparam logic [SS_BITS:0] CNT_MAX = (SS_BITS + 1)'(SS);

    logic [PHYS_BITS-1:0] map_q [NUM_ARCH];
    logic [PHYS_BITS-1:0] map_d [NUM_ARCH];
    logic [SS-1:0]        freed_valid_q;
    logic [SS-1:0]        freed_valid_d;
    logic [PHYS_BITS-1:0] freed_phys_q [SS];
    logic [PHYS_BITS-1:0] freed_phys_d [SS];
    logic [SS_BITS:0]     eff_cnt;

    // Slots are folded into map_d in program order, so a later slot that
    // targets the same arch reg sees (and displaces) the earlier slot's phys
    // rather than the stale committed entry. Writes to x0 are no-ops: branches
    // and stores commit with arch 0.
    always_comb begin
        eff_cnt = (commit_cnt > CNT_MAX) ? CNT_MAX : commit_cnt;
        for (int a = 0; a < NUM_ARCH; a++) begin
            map_d[a] = map_q[a];
        end
        freed_valid_d = '0;
        for (int i = 0; i < SS; i++) begin
            freed_phys_d[i] = '0;
            if (((SS_BITS + 1)'(i) < eff_cnt) && (rrf_arch_reg[i] != '0)) begin
                freed_valid_d[i]            = 1'b1;
                freed_phys_d[i]             = map_d[rrf_arch_reg[i]];
                map_d[rrf_arch_reg[i]]      = rrf_phys_reg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                map_q[a] <= PHYS_BITS'(a);
            end
            freed_valid_q <= '0;
            for (int i = 0; i < SS; i++) begin
                freed_phys_q[i] <= '0;
            end
        end else begin
            map_q         <= map_d;
            freed_valid_q <= freed_valid_d;
            freed_phys_q  <= freed_phys_d;
        end
    end

    assign freed_valid   = freed_valid_q;
    assign freed_phys    = freed_phys_q;
    assign restore_valid = mispredict;
    // The front-end RAT restores in the same cycle, so it must see this
    // cycle's commits as well.
    assign restore_map   = map_d;

    // Illegal commit count, phys 0 never freed (it belongs to x0), and no two
    // architectural registers sharing a physical register.
    always @(posedge clk) begin
        if (!rst) begin
            assert (commit_cnt <= CNT_MAX);
            for (int i = 0; i < SS; i++) begin
                assert (!freed_valid_q[i] || (freed_phys_q[i] != '0));
            end
            for (int a = 1; a < NUM_ARCH; a++) begin
                for (int b = a + 1; b < NUM_ARCH; b++) begin
                    assert (map_q[a] != map_q[b]);
                end
            end
        end
    end

endmodule
